// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Pipeline hazard unit for a classic 5-stage in-order pipeline. Detects
// load-use hazards between ID/EX and IF/ID, inserts LOAD_USE_STALLS bubble
// cycles, flushes IF/ID on a taken branch, and freezes the whole pipeline
// while data memory is busy.
//
// Optional feature: define HAZARD_STATS_EN to build the 16-bit saturating
// load-use bubble counter behind stallCycles. Without it the port reads 0.
//
// Parameters
//   LOAD_USE_STALLS  bubble cycles per load-use hazard (1..3)
//   REG_ADDR_W       register address width
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   memReadIdEx    in   ID/EX instruction is a load
//   rtIdEx         in   load destination register in ID/EX
//   rsIfId         in   rs source of the IF/ID instruction
//   rtIfId         in   rt source of the IF/ID instruction
//   usesRtIfId     in   IF/ID instruction reads rt
//   branchTakenEx  in   branch/jump resolved taken in EX
//   memBusy        in   data memory not ready
//   pcWrite        out  PC update enable
//   ifIdWrite      out  IF/ID write enable
//   ifIdFlush      out  clear IF/ID to a NOP
//   hzdControl     out  select zero control into ID/EX (bubble)
//   pipeFreeze     out  hold all pipeline registers
//   stallCycles    out  count of load-use bubble cycles
// -----------------------------------------------------------------------------
module hazard_controller #(
  parameter int LOAD_USE_STALLS = 1,
  parameter int REG_ADDR_W      = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memReadIdEx,
  input  logic [REG_ADDR_W-1:0] rtIdEx,
  input  logic [REG_ADDR_W-1:0] rsIfId,
  input  logic [REG_ADDR_W-1:0] rtIfId,
  input  logic                  usesRtIfId,
  input  logic                  branchTakenEx,
  input  logic                  memBusy,
  output logic                  pcWrite,
  output logic                  ifIdWrite,
  output logic                  ifIdFlush,
  output logic                  hzdControl,
  output logic                  pipeFreeze,
  output logic [15:0]           stallCycles
);

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // Bubbles still owed after the one issued in the detecting cycle.
  localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_STALLS - 1);

  state_t     state, state_next;
  logic [1:0] cnt, cnt_next;
  logic       hazard;

  // Register 0 is hard-wired zero, so a load "into" it never creates a hazard.
  assign hazard = memReadIdEx && (rtIdEx != '0) &&
                  ((rtIdEx == rsIfId) || (usesRtIfId && (rtIdEx == rtIfId)));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    hzdControl = 1'b0;
    pipeFreeze = 1'b0;
    if (!reset) begin
      // Outputs forced to the free-running pattern while reset is held.
    end else if (memBusy) begin
      // Freeze wins over everything; state and cnt hold.
      pipeFreeze = 1'b1;
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (branchTakenEx) begin
            // Flush the wrong-path instruction and bubble ID/EX; the
            // squashed instruction makes any coincident hazard moot.
            ifIdFlush  = 1'b1;
            hzdControl = 1'b1;
          end else if (hazard) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            hzdControl = 1'b1;
            if (LOAD_USE_STALLS > 1) begin
              state_next = STALL;
              cnt_next   = CNT_INIT;
            end
          end
        end
        STALL: begin
          pcWrite    = 1'b0;
          ifIdWrite  = 1'b0;
          hzdControl = 1'b1;
          cnt_next   = cnt - 2'd1;
          if (cnt == 2'd1) begin
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  // A bubble without a flush can only come from a load-use hazard; freeze
  // and reset both force hzdControl low, so they never count.
  logic        load_use_bubble;
  logic [15:0] stall_count;

  assign load_use_bubble = hzdControl && !ifIdFlush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (load_use_bubble && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  assign stallCycles = stall_count;
`else
  assign stallCycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // Output pattern order: {pcWrite, ifIdWrite, ifIdFlush, hzdControl, pipeFreeze}
  localparam logic [4:0] O_RUN    = 5'b11000;
  localparam logic [4:0] O_BUBBLE = 5'b00010;
  localparam logic [4:0] O_BRANCH = 5'b11110;
  localparam logic [4:0] O_FREEZE = 5'b00001;

  logic       clock = 1'b0;
  logic       reset;
  logic       memReadIdEx;
  logic [4:0] rtIdEx, rsIfId, rtIfId;
  logic       usesRtIfId, branchTakenEx, memBusy;

  logic [4:0]  obs [3];
  logic [15:0] sc  [3];

  always #5 clock = ~clock;

  // Instances with LOAD_USE_STALLS = 1, 2, 3 share one stimulus stream.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic pw, iw, fl, hz, fz;
    logic [15:0] cyc;
    hazard_controller #(.LOAD_USE_STALLS(g + 1), .REG_ADDR_W(5)) dut (
      .clock(clock), .reset(reset), .memReadIdEx(memReadIdEx),
      .rtIdEx(rtIdEx), .rsIfId(rsIfId), .rtIfId(rtIfId),
      .usesRtIfId(usesRtIfId), .branchTakenEx(branchTakenEx),
      .memBusy(memBusy), .pcWrite(pw), .ifIdWrite(iw), .ifIdFlush(fl),
      .hzdControl(hz), .pipeFreeze(fz), .stallCycles(cyc)
    );
    assign obs[g] = {pw, iw, fl, hz, fz};
    assign sc[g]  = cyc;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: bubbles still owed and bubbles issued so far, per instance.
  int rem   [3] = '{0, 0, 0};
  int stats [3] = '{0, 0, 0};
  int bub   [3] = '{0, 0, 0};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hz_now();
    return memReadIdEx && (rtIdEx != 0) &&
           ((rtIdEx == rsIfId) || (usesRtIfId && (rtIdEx == rtIfId)));
  endfunction

  function automatic logic [4:0] model_out(input int i);
    if (!reset)        return O_RUN;
    if (memBusy)       return O_FREEZE;
    if (rem[i] > 0)    return O_BUBBLE;
    if (branchTakenEx) return O_BRANCH;
    if (hz_now())      return O_BUBBLE;
    return O_RUN;
  endfunction

  function automatic int model_sc(input int i);
    if (!STATS || !reset) return 0;
    return stats[i];
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < 3; i++) begin
      if (!reset) begin
        rem[i] = 0; stats[i] = 0;
      end else if (memBusy) begin
        // frozen
      end else if (rem[i] > 0) begin
        rem[i]--;
        if (stats[i] < 65535) stats[i]++;
      end else if (branchTakenEx) begin
        // flush only
      end else if (hz_now()) begin
        rem[i] = i;  // LOAD_USE_STALLS - 1
        if (stats[i] < 65535) stats[i]++;
      end
    end
  endfunction

  // Drive one cycle of inputs, compare every instance, then take the edge.
  task automatic step(input logic r, input logic mr, input logic [4:0] re,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic ur, input logic br, input logic mb);
    reset = r; memReadIdEx = mr; rtIdEx = re; rsIfId = rs; rtIfId = rt;
    usesRtIfId = ur; branchTakenEx = br; memBusy = mb;
    #2;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("outs_n%0d", i + 1), int'(obs[i]), int'(model_out(i)));
      check($sformatf("stallCycles_n%0d", i + 1), int'(sc[i]), model_sc(i));
      if (obs[i] == O_BUBBLE) bub[i]++;
    end
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) bub[i] = 0;
  endtask

  typedef struct {
    string      name;
    logic       mr;
    logic [4:0] re, rs, rt;
    logic       ur, br, mb;
    logic [4:0] exp1;  // expected outputs of the single-bubble instance
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{"no_load",      1'b0, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN};
    tbl[1] = '{"rs_hazard",    1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, O_BUBBLE};
    tbl[2] = '{"r0_no_hazard", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, O_RUN};
    tbl[3] = '{"rt_hazard",    1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, O_BUBBLE};
    tbl[4] = '{"rt_unused",    1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, O_RUN};
    tbl[5] = '{"hz_and_branch",1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, O_BRANCH};
    tbl[6] = '{"busy_hazard",  1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, O_FREEZE};
    tbl[7] = '{"branch_only",  1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, O_BRANCH};

    do_reset();
    // Each vector starts from RUN: reset between vectors so the multi-bubble
    // instances do not carry a stall into the next vector.
    for (int v = 0; v < 8; v++) begin
      do_reset();
      reset = 1'b1; memReadIdEx = tbl[v].mr; rtIdEx = tbl[v].re;
      rsIfId = tbl[v].rs; rtIfId = tbl[v].rt; usesRtIfId = tbl[v].ur;
      branchTakenEx = tbl[v].br; memBusy = tbl[v].mb;
      #1;
      check({"tbl_", tbl[v].name}, int'(obs[0]), int'(tbl[v].exp1));
      step(1'b1, tbl[v].mr, tbl[v].re, tbl[v].rs, tbl[v].rt,
           tbl[v].ur, tbl[v].br, tbl[v].mb);
    end

    // Single hazard: 1, 2 and 3 bubbles respectively, then free running.
    do_reset();
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) idle();
    check("seq_bubbles_n1", bub[0], 1);
    check("seq_bubbles_n2", bub[1], 2);
    check("seq_bubbles_n3", bub[2], 3);
    check("seq_sc_n1", int'(sc[0]), STATS ? 1 : 0);
    check("seq_sc_n3", int'(sc[2]), STATS ? 3 : 0);
    check("seq_after_n3", int'(obs[2]), int'(O_RUN));

    // Branch with simultaneous hazard: flush, no stall, counter unchanged.
    do_reset();
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0);
    idle();
    check("br_hz_bubbles_n3", bub[2], 0);
    check("br_hz_sc_n3", int'(sc[2]), 0);

    // Freeze for two cycles in the middle of a 3-bubble stall.
    do_reset();
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    repeat (4) idle();
    check("freeze_bubbles_n3", bub[2], 3);
    check("freeze_sc_n3", int'(sc[2]), STATS ? 3 : 0);

    // Asynchronous reset in the middle of a stall.
    do_reset();
    step(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1; memReadIdEx = 1'b0; branchTakenEx = 1'b0; memBusy = 1'b0;
    #2;
    check("pre_areset_outs_n3", int'(obs[2]), int'(O_BUBBLE));
    check("pre_areset_sc_n3", int'(sc[2]), STATS ? 1 : 0);
    reset = 1'b0;
    #1;
    check("areset_outs_n3", int'(obs[2]), int'(O_RUN));
    check("areset_sc_n3", int'(sc[2]), 0);
    for (int i = 0; i < 3; i++) begin rem[i] = 0; stats[i] = 0; end
    @(posedge clock);
    #1;
    bub[2] = 0;
    repeat (3) idle();
    check("areset_resume_n3", bub[2], 0);

    // Randomized traffic on a small register set to provoke frequent hits.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 49) != 0),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter LOAD_USE_STALLS, default 1, bubble cycles per load-use hazard (legal 1..3).
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port memReadIdEx  input  1  the instruction in ID/EX is a load.
REQ-006 SHALL have port rtIdEx  input  REG_ADDR_W  load destination register in ID/EX.
REQ-007 SHALL have port rsIfId  input  REG_ADDR_W  rs source register of the instruction in IF/ID.
REQ-008 SHALL have port rtIfId  input  REG_ADDR_W  rt source register of the instruction in IF/ID.
REQ-009 SHALL have port usesRtIfId  input  1  the IF/ID instruction reads rt.
REQ-010 SHALL have port branchTakenEx  input  1  branch/jump resolved taken in EX.
REQ-011 SHALL have port memBusy  input  1  data memory not ready; the pipeline must freeze.
REQ-012 SHALL have port pcWrite  output  1  PC update enable.
REQ-013 SHALL have port ifIdWrite  output  1  IF/ID register write enable.
REQ-014 SHALL have port ifIdFlush  output  1  clear IF/ID to a NOP.
REQ-015 SHALL have port hzdControl  output  1  zero-control select for the ID/EX control mux (inserts a bubble).
REQ-016 SHALL have port pipeFreeze  output  1  hold all pipeline registers.
REQ-017 SHALL have port stallCycles  output  16  count of load-use bubble cycles.

Function
REQ-018 SHALL define hazard = memReadIdEx & (rtIdEx != 0) & ((rtIdEx == rsIfId) | (usesRtIfId & (rtIdEx == rtIfId))).
REQ-019 SHALL implement a 2-state FSM: RUN and STALL, with a 2-bit remaining-bubble counter cnt.
REQ-020 SHALL give memBusy priority over all other inputs.
- When memBusy=1: pipeFreeze=1, pcWrite=0, ifIdWrite=0, ifIdFlush=0, hzdControl=0.
- FSM state, cnt and stallCycles hold.
REQ-021 SHALL, in RUN with branchTakenEx=1 and memBusy=0:
- Drive pcWrite=1, ifIdWrite=1, ifIdFlush=1, hzdControl=1 for that cycle.
- Remain in RUN; branch takes priority over a simultaneous hazard.
REQ-022 SHALL, in RUN with a hazard, branchTakenEx=0 and memBusy=0:
- Drive pcWrite=0, ifIdWrite=0, hzdControl=1 combinationally in the same cycle.
- If LOAD_USE_STALLS>1, go to STALL with cnt=LOAD_USE_STALLS-1; otherwise stay in RUN.
REQ-023 SHALL, in STALL with memBusy=0:
- Drive pcWrite=0, ifIdWrite=0, hzdControl=1 and decrement cnt.
- Return to RUN on the edge where cnt reaches 0.
- Ignore branchTakenEx and new hazards while in STALL.
REQ-024 SHALL, in RUN with no hazard, branch or memBusy: drive pcWrite=1, ifIdWrite=1 and all other outputs 0.
REQ-025 SHALL make all outputs combinational from state, cnt and inputs, with no additional latency.
REQ-026 SHALL increment stallCycles once per edge in which hzdControl=1 due to a load-use hazard and memBusy=0; it saturates at 16'hFFFF.

Reset
REQ-027 SHALL, while reset=0, asynchronously force state=RUN, cnt=0 and stallCycles=0.
REQ-028 SHALL drive outputs during reset as: pcWrite=1, ifIdWrite=1, ifIdFlush=0, hzdControl=0, pipeFreeze=0.
REQ-029 SHALL, on reset asserted mid-stall, abandon the remaining bubbles and resume in RUN after release.

Configuration
REQ-030 SHALL use macro HAZARD_STATS_EN to control the stall counter.
- Defined: stallCycles counter is implemented per REQ-026.
- Undefined: no counter logic; stallCycles is tied to 16'h0000; the port remains present.

Verification
REQ-031 SHALL cover: LOAD_USE_STALLS=1, memReadIdEx=1, rtIdEx=5, rsIfId=5 -> one cycle with pcWrite=0, ifIdWrite=0, hzdControl=1, then RUN; stallCycles=1.
REQ-032 SHALL cover: LOAD_USE_STALLS=3, same hazard -> three consecutive bubble cycles, then pcWrite=1; stallCycles=3.
REQ-033 SHALL cover: rtIdEx=0 matching rsIfId=0 with memReadIdEx=1 -> no stall, pcWrite=1.
REQ-034 SHALL cover: hazard and branchTakenEx=1 in the same cycle -> ifIdFlush=1, hzdControl=1, pcWrite=1; stallCycles unchanged.
REQ-035 SHALL cover: memBusy=1 for 2 cycles in the middle of a 3-cycle stall -> pipeFreeze=1, cnt holds, total bubble cycles still 3.
REQ-036 SHALL cover: reset=0 asserted in STALL -> state=RUN and stallCycles=0 immediately, without a clock edge.
